// File: rtl/seg7_scan_ctrl.sv
// Multi-digit seven-segment scan controller with start/stop run-mode handshake.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int          NDIG     = 4,
    parameter int          SCAN_DIV = 1000,
    parameter logic [6:0]  ESEG     = 7'b1111100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   inval,
    output logic [1:0]        mode,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic              frame_done
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);

    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_RUN  = 2'd1;
    localparam logic [1:0] MODE_STOP = 2'd2;

    logic [1:0]        r_mode;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [4*NDIG-1:0] r_shadow_val;
    logic [NDIG-1:0]   r_shadow_inv;
    logic [4*NDIG-1:0] r_disp_val;
    logic [NDIG-1:0]   r_disp_inv;
    logic [6:0]        r_seg;
    logic [NDIG-1:0]   r_an;
    logic              r_frame_done;

    logic              w_active;
    logic              w_slot_end;
    logic              w_boundary;
    logic [3:0]        w_nib;
    logic              w_inv;
    logic              w_blank_cur;
    logic [6:0]        w_hex;
    logic [6:0]        w_seg;
    logic [NDIG-1:0]   w_an;

    assign w_active   = (r_mode != MODE_IDLE);
    assign w_slot_end = (r_cnt == CNT_MAX);
    assign w_boundary = w_active && w_slot_end && (r_idx == LAST_IDX);

    assign w_nib = 4'(r_disp_val >> {r_idx, 2'b00});
    assign w_inv = r_disp_inv[r_idx];
    assign w_an  = NDIG'(1) << r_idx;

    always_comb begin
        case (w_nib)
            4'h0:    w_hex = 7'h3F;
            4'h1:    w_hex = 7'h06;
            4'h2:    w_hex = 7'h5B;
            4'h3:    w_hex = 7'h4F;
            4'h4:    w_hex = 7'h66;
            4'h5:    w_hex = 7'h6D;
            4'h6:    w_hex = 7'h7D;
            4'h7:    w_hex = 7'h07;
            4'h8:    w_hex = 7'h7F;
            4'h9:    w_hex = 7'h6F;
            4'hA:    w_hex = 7'h77;
            4'hB:    w_hex = 7'h7C;
            4'hC:    w_hex = 7'h39;
            4'hD:    w_hex = 7'h5E;
            4'hE:    w_hex = 7'h79;
            default: w_hex = 7'h71;
        endcase
    end

`ifdef SEG7_LZB_EN
    logic [NDIG-1:0] w_blank;

    // Walk down from the top digit; blanking stops at the first nonzero or invalid digit.
    always_comb begin
        logic v_run;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        v_run   = 1'b1;
        w_blank = '0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            v_run      = v_run & (r_disp_val[4*i +: 4] == 4'd0) & ~r_disp_inv[i];
            w_blank[i] = v_run;
        end
    end

    assign w_blank_cur = w_blank[r_idx];
`else
    assign w_blank_cur = 1'b0;
`endif

    assign w_seg = w_inv ? ESEG : (w_blank_cur ? 7'd0 : w_hex);

    // NOTE: non-blocking assignments make a load on a boundary edge leave the old shadow in the display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode       <= MODE_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow_val <= '0;
            r_shadow_inv <= '0;
            r_disp_val   <= '0;
            r_disp_inv   <= '0;
            r_seg        <= '0;
            r_an         <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (load) begin
                r_shadow_val <= value;
                r_shadow_inv <= inval;
            end

            r_frame_done <= 1'b0;

            case (r_mode)
                MODE_IDLE: begin
                    if (start) begin
                        r_mode     <= stop ? MODE_STOP : MODE_RUN;
                        r_cnt      <= '0;
                        r_idx      <= '0;
                        r_disp_val <= r_shadow_val;
                        r_disp_inv <= r_shadow_inv;
                    end
                end
                MODE_RUN, MODE_STOP: begin
                    if (w_slot_end) begin
                        r_cnt <= '0;
                        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end

                    if (w_boundary) begin
                        r_disp_val   <= r_shadow_val;
                        r_disp_inv   <= r_shadow_inv;
                        r_frame_done <= 1'b1;
                    end

                    if (r_mode == MODE_RUN) begin
                        if (stop) r_mode <= MODE_STOP;
                    end else if (start) begin
                        r_mode <= MODE_RUN;
                    end else if (w_boundary) begin
                        r_mode <= MODE_IDLE;
                    end
                end
                default: r_mode <= MODE_IDLE;
            endcase

            // Outputs trail the scan state by one cycle.
            if (w_active) begin
                r_an  <= w_an;
                r_seg <= w_seg;
            end else begin
                r_an  <= '0;
                r_seg <= '0;
            end
        end
    end

    assign mode       = r_mode;
    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-position reference model queues the expected
// outputs for every clock and a separate monitor compares them against the DUT.
module tb_seg7_scan_ctrl;

    localparam int         NDIG     = 4;
    localparam int         SCAN_DIV = 4;
    localparam int         FRAME    = NDIG * SCAN_DIV;
    localparam logic [6:0] ESEG     = 7'b1111100;

    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        load;
    logic [15:0] value;
    logic [3:0]  inval;
    logic [1:0]  mode;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;

    // Reference model: run state, cycle position within the frame, shadow and displayed data.
    int          m_mode;
    int          m_pos;
    logic [15:0] m_sh_v;
    logic [3:0]  m_sh_i;
    logic [15:0] m_dp_v;
    logic [3:0]  m_dp_i;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_scan_ctrl #(
        .NDIG     (NDIG),
        .SCAN_DIV (SCAN_DIV),
        .ESEG     (ESEG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .load       (load),
        .value      (value),
        .inval      (inval),
        .mode       (mode),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int d, input logic [15:0] v, input logic [3:0] iv);
        logic [3:0] nib;
        logic       all_zero;
        nib = v[d*4 +: 4];
        if (iv[d]) return ESEG;
`ifdef SEG7_LZB_EN
        if (d > 0) begin
            all_zero = 1'b1;
            for (int j = d; j < NDIG; j++)
                if (v[j*4 +: 4] != 4'd0 || iv[j]) all_zero = 1'b0;
            if (all_zero) return 7'd0;
        end
`else
        all_zero = 1'b0;
`endif
        return hex_tab[nib];
    endfunction

    // Drive one cycle of stimulus and queue what the outputs must show after the coming edge.
    task automatic step(input logic s, input logic p, input logic l,
                        input logic [15:0] v, input logic [3:0] iv);
        exp_t e;
        int   d;
        logic bnd;
        @(negedge clk);
        start = s;
        stop  = p;
        load  = l;
        value = v;
        inval = iv;

        d   = m_pos / SCAN_DIV;
        bnd = (m_mode != 0) && (m_pos == FRAME - 1);
        if (m_mode != 0) begin
            e.an  = 4'(1 << d);
            e.seg = exp_seg(d, m_dp_v, m_dp_i);
        end else begin
            e.an  = 4'd0;
            e.seg = 7'd0;
        end
        e.fd = bnd;

        if (m_mode == 0) begin
            if (s) begin
                m_mode = p ? 2 : 1;
                m_pos  = 0;
                m_dp_v = m_sh_v;
                m_dp_i = m_sh_i;
            end
        end else begin
            m_pos = (m_pos + 1) % FRAME;
            if (bnd) begin
                m_dp_v = m_sh_v;
                m_dp_i = m_sh_i;
            end
            if (m_mode == 1) begin
                if (p) m_mode = 2;
            end else if (s) begin
                m_mode = 1;
            end else if (bnd) begin
                m_mode = 0;
            end
        end
        if (l) begin
            m_sh_v = v;
            m_sh_i = iv;
        end

        e.mode = 2'(m_mode);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
    endtask

    task automatic run_until_pos(input int p);
        for (int k = 0; k < FRAME && m_pos != p; k++) idle(1);
    endtask

    always @(posedge clk) begin
        exp_t e;
        exp_t got;
        #2;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {mode, an, seg, frame_done};
            check("scan {mode,an,seg,fd}", 32'(got), 32'(e));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec  = 0;
        n_err  = 0;
        m_mode = 0;
        m_pos  = 0;
        m_sh_v = '0;
        m_sh_i = '0;
        m_dp_v = '0;
        m_dp_i = '0;
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        load   = 1'b0;
        value  = '0;
        inval  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset mode", 32'(mode), 32'd0);
        check("reset an", 32'(an), 32'd0);
        check("reset seg", 32'(seg), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;

        idle(4);

        // Basic frame: F, A, 2, 1 over two frames.
        step(1'b0, 1'b0, 1'b1, 16'h12AF, 4'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        idle(2 * FRAME);

        // Invalid digit and (optionally) leading-zero blanking.
        step(1'b0, 1'b0, 1'b1, 16'h0005, 4'b0100);
        idle(FRAME + 2);

        // Mid-frame load must not disturb the frame being shown.
        step(1'b0, 1'b0, 1'b1, 16'h1234, 4'h0);
        run_until_pos(FRAME - 1);
        idle(1);
        run_until_pos(5);
        step(1'b0, 1'b0, 1'b1, 16'h9999, 4'h0);
        idle(2 * FRAME);

        // Load exactly on a frame boundary.
        run_until_pos(FRAME - 1);
        step(1'b0, 1'b0, 1'b1, 16'h4321, 4'h0);
        idle(2 * FRAME);

        // Stop during digit 1.
        run_until_pos(SCAN_DIV + 1);
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        idle(FRAME + 2);

        // Start while stopping cancels the stop.
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        run_until_pos(SCAN_DIV);
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        idle(20);
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        idle(FRAME + 2);

        // Start and stop together from idle: one frame only.
        step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        idle(FRAME + 4);

        // Asynchronous reset during digit 2 clears everything including the shadow.
        step(1'b0, 1'b0, 1'b1, 16'hBEEF, 4'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        idle(FRAME);
        run_until_pos(2 * SCAN_DIV + 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst mid-run mode", 32'(mode), 32'd0);
        check("rst mid-run an", 32'(an), 32'd0);
        check("rst mid-run seg", 32'(seg), 32'd0);
        check("rst mid-run frame_done", 32'(frame_done), 32'd0);
        m_mode = 0;
        m_pos  = 0;
        m_sh_v = '0;
        m_sh_i = '0;
        m_dp_v = '0;
        m_dp_i = '0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        idle(FRAME + 2);
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        idle(FRAME + 2);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 29) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 7) == 0,
                 16'($urandom),
                 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)));
        end
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        idle(2 * FRAME);

        repeat (2) @(posedge clk);
        #3;
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multi-digit seven-segment scan controller with a start/done run-mode handshake. It latches a packed hex value, decodes one nibble per digit and time-multiplexes the digits onto a shared segment bus. Digit data is refreshed only at frame boundaries, so a display never shows a half-updated value. It sits between the lab datapath (value producer) and the board's segment/anode pins, replacing single-digit fixed-pattern drivers.

## Interface
- NDIG, 4: number of digits, 1..8.
- SCAN_DIV, 1000: clock cycles each digit stays lit, ≥2.
- ESEG, 7'b1111100: segment pattern driven on a digit whose nibble is flagged invalid.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  single-cycle request to begin scanning.
- stop  input  1  single-cycle request to end scanning at the next frame boundary.
- load  input  1  capture value/inval into the shadow register.
- value  input  4*NDIG  packed hex digits; digit 0 is value[3:0].
- inval  input  NDIG  per-digit invalid flag; a set flag shows ESEG.
- mode  output  2  run state: 0 IDLE, 1 RUN, 2 STOPPING.
- seg  output  7  segments a..g on seg[0]..seg[6], active-high.
- an  output  NDIG  digit enable, one-hot active-high, all-zero when blank.
- frame_done  output  1  one-cycle pulse when the last digit's slot ends.

## Operation
- Shadow register is written on load in any state. The display register copies the shadow at every frame boundary and on IDLE→RUN.
- Decode: standard hex 0–F. A digit whose inval bit is set shows ESEG regardless of its nibble.
- States:
  - IDLE: an=0, seg=0. On start → RUN, digit index 0, scan counter 0, display register takes the shadow.
  - RUN: scan counter counts 0..SCAN_DIV-1. At SCAN_DIV-1 the index advances and wraps from NDIG-1 to 0. The wrap is a frame boundary: frame_done pulses and the display register updates. stop → STOPPING.
  - STOPPING: scanning continues. At the next frame boundary frame_done pulses and the state goes to IDLE with an=0 and seg=0 in the following cycle.
- start in RUN or STOPPING: ignored, except that start in STOPPING cancels the stop and returns to RUN with no gap in scanning.
- start and stop asserted in the same cycle in IDLE: start wins, then stop is honoured, giving exactly one frame.
- load coinciding with a frame boundary: the display register takes the old shadow value; the new value appears at the next boundary.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values. The shadow register clears.

## Timing
- Reset values: mode=0, seg=0, an=0, frame_done=0, scan counter 0, index 0, shadow 0, inval shadow 0.
- seg, an and frame_done are registered.
- Start latency: start sampled at edge N puts an=1 (digit 0) and the decoded seg on the outputs after edge N+1.
- Each digit is lit for exactly SCAN_DIV cycles. A frame lasts NDIG×SCAN_DIV cycles.
- frame_done is high during the final cycle of digit NDIG-1's slot.
- Load-to-display latency is at most one frame plus one cycle.

## Configuration
- SEG7_LZB_EN defined: leading-zero blanking.
  - Digits above the most-significant nonzero, valid digit show seg=0 while their an slot is still asserted, so timing is unchanged.
  - Digit 0 is never blanked.
  - A digit with its inval bit set is never blanked and stops blanking of the digits below it.
- SEG7_LZB_EN undefined: every digit is decoded; a zero digit shows 7'b0111111.

## Test plan
- Reset mid-RUN, with NDIG=4 and SCAN_DIV=4: assert rst during digit 2 → the next cycle shows mode=0, an=0, seg=0, and shadow=0.
- Load value=16'h12AF, then start → an sequence 0001,0010,0100,1000 with 4 cycles each; seg sequence 0x71(F), 0x77(A), 0x5B(2), 0x06(1); frame_done pulses every 16 cycles.
- Load 16'h0005 with inval=4'b0100 → digit 2 shows 7'b1111100. Under SEG7_LZB_EN, digit 3 shows 0 and digit 1 shows 0x3F, because the inval digit above it blocks blanking.
- Mid-frame load of 16'h9999 while showing 16'h1234 → outputs unchanged until the frame boundary, then 0x6F on every digit.
- stop at digit 1 → scanning finishes digit 3, frame_done pulses, and mode=0 the next cycle. Repeat with start issued in STOPPING → mode returns to 1 with no blank cycle.
- start and stop in the same IDLE cycle → exactly one frame (16 cycles) is shown, then IDLE.
